// File: rtl/temp_from_adc_pkg.sv
// Shared definitions for the NTC temperature converter.
//   T_MIN / T_STEP / N_TBL : table origin (degC), spacing (degC) and entry count
//   state_t                : converter sequencing states
//   tbl_at(idx)            : resistance ROM. Entry i is the thermistor resistance
//                            at T_MIN + T_STEP*i, in units of 0.1 ohm scaled so
//                            that 25 degC reads 1000000. Entries strictly
//                            decrease with index.
package temp_from_adc_pkg;

  localparam int T_MIN  = -55;
  localparam int T_STEP = 5;
  localparam int N_TBL  = 72;
  localparam int TBL_W  = 32;

  typedef enum logic [2:0] {
    IDLE,
    DIV_K,
    MUL,
    DIV_R,
    SEARCH,
    INTERP,
    DONE
  } state_t;

  function automatic logic [TBL_W-1:0] tbl_at(input logic [6:0] idx);
    case (idx)
      7'd0:  tbl_at = 32'd128820000;
      7'd1:  tbl_at = 32'd85860000;
      7'd2:  tbl_at = 32'd58250000;
      7'd3:  tbl_at = 32'd40185000;
      7'd4:  tbl_at = 32'd28157000;
      7'd5:  tbl_at = 32'd20020000;
      7'd6:  tbl_at = 32'd14431000;
      7'd7:  tbl_at = 32'd10539000;
      7'd8:  tbl_at = 32'd7790000;
      7'd9:  tbl_at = 32'd5825000;
      7'd10: tbl_at = 32'd4403000;
      7'd11: tbl_at = 32'd3362000;
      7'd12: tbl_at = 32'd2592000;
      7'd13: tbl_at = 32'd2018000;
      7'd14: tbl_at = 32'd1584000;
      7'd15: tbl_at = 32'd1254000;
      7'd16: tbl_at = 32'd1000000;
      7'd17: tbl_at = 32'd803700;
      7'd18: tbl_at = 32'd650600;
      7'd19: tbl_at = 32'd530200;
      7'd20: tbl_at = 32'd434800;
      7'd21: tbl_at = 32'd358800;
      7'd22: tbl_at = 32'd297800;
      7'd23: tbl_at = 32'd248600;
      7'd24: tbl_at = 32'd208700;
      7'd25: tbl_at = 32'd176000;
      7'd26: tbl_at = 32'd149200;
      7'd27: tbl_at = 32'd127000;
      7'd28: tbl_at = 32'd108700;
      7'd29: tbl_at = 32'd93380;
      7'd30: tbl_at = 32'd80520;
      7'd31: tbl_at = 32'd69750;
      7'd32: tbl_at = 32'd60630;
      7'd33: tbl_at = 32'd52900;
      7'd34: tbl_at = 32'd46320;
      7'd35: tbl_at = 32'd40700;
      7'd36: tbl_at = 32'd35880;
      7'd37: tbl_at = 32'd31730;
      7'd38: tbl_at = 32'd28140;
      7'd39: tbl_at = 32'd25030;
      7'd40: tbl_at = 32'd22330;
      7'd41: tbl_at = 32'd19970;
      7'd42: tbl_at = 32'd17900;
      7'd43: tbl_at = 32'd16100;
      7'd44: tbl_at = 32'd14510;
      7'd45: tbl_at = 32'd13100;
      7'd46: tbl_at = 32'd11860;
      7'd47: tbl_at = 32'd10760;
      7'd48: tbl_at = 32'd9785;
      7'd49: tbl_at = 32'd8915;
      7'd50: tbl_at = 32'd8139;
      7'd51: tbl_at = 32'd7445;
      7'd52: tbl_at = 32'd6823;
      7'd53: tbl_at = 32'd6264;
      7'd54: tbl_at = 32'd5761;
      7'd55: tbl_at = 32'd5307;
      7'd56: tbl_at = 32'd4897;
      7'd57: tbl_at = 32'd4526;
      7'd58: tbl_at = 32'd4189;
      7'd59: tbl_at = 32'd3884;
      7'd60: tbl_at = 32'd3605;
      7'd61: tbl_at = 32'd3352;
      7'd62: tbl_at = 32'd3121;
      7'd63: tbl_at = 32'd2909;
      7'd64: tbl_at = 32'd2716;
      7'd65: tbl_at = 32'd2539;
      7'd66: tbl_at = 32'd2375;
      7'd67: tbl_at = 32'd2225;
      7'd68: tbl_at = 32'd2087;
      7'd69: tbl_at = 32'd1961;
      7'd70: tbl_at = 32'd1843;
      7'd71: tbl_at = 32'd1734;
      default: tbl_at = '0;
    endcase
  endfunction

endpackage

// File: rtl/temp_from_adc_seq_divider.sv
// Restoring unsigned divider, one quotient bit per clock.
//   clk, rst  : clock and synchronous active-high reset (clears all state)
//   start     : load dividend/divisor and begin; restarts a running division
//   dividend  : W-bit numerator
//   divisor   : W-bit denominator (zero yields an all-ones quotient)
//   busy      : high while iterating
//   done      : one-cycle pulse; quotient is valid from this cycle onward
//   quotient  : floor(dividend / divisor)
module seq_divider #(
  parameter int W = 48
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] quotient
);

  localparam int CNT_W = $clog2(W + 1);

  logic [W-1:0]     rem;
  logic [W-1:0]     quo;
  logic [CNT_W-1:0] cnt;
  logic [W:0]       rem_sh;
  logic [W:0]       diff;

  // Shift the next dividend bit into the partial remainder and trial-subtract.
  // The remainder stays below the divisor, so W+1 bits hold the shifted value.
  always_comb begin
    rem_sh = {rem, quo[W-1]};
    diff   = rem_sh - {1'b0, divisor};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem  <= '0;
      quo  <= '0;
      cnt  <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        rem  <= '0;
        quo  <= dividend;
        cnt  <= CNT_W'(W);
        busy <= 1'b1;
      end else if (busy) begin
        if (!diff[W]) begin
          rem <= diff[W-1:0];
          quo <= {quo[W-2:0], 1'b1};
        end else begin
          rem <= rem_sh[W-1:0];
          quo <= {quo[W-2:0], 1'b0};
        end
        cnt <= cnt - 1'b1;
        if (cnt == CNT_W'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  assign quotient = quo;

endmodule

// File: rtl/temp_from_adc.sv
// Converts an ADC reading of an NTC/series-resistor divider into degC.
//   clk, rst  : clock and synchronous active-high reset
//   start     : conversion request, accepted only when idle
//   adc_code  : measured divider code (12-bit unsigned)
//   res       : series resistor in ohms
//   voltage   : supply voltage scaled by k
//   k         : voltage scale factor
//   busy      : conversion in progress
//   done      : one-cycle pulse when temp/clamp/err are updated
//   temp      : signed temperature, -55..300 degC
//   clamp     : result saturated at a table end
//   err       : inputs could not produce a resistance
// Flow: q = 1000/k, vfs = q*voltage, rt = adc*10*res/(vfs-adc), linear table
// scan for the bracketing entry pair, then a divide for the fractional step.
module temp_from_adc
  import temp_from_adc_pkg::*;
#(
  parameter int DIV_W = 48
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [11:0]        adc_code,
  input  logic [31:0]        res,
  input  logic [31:0]        voltage,
  input  logic [31:0]        k,
  output logic               busy,
  output logic               done,
  output logic signed [11:0] temp,
  output logic               clamp,
  output logic               err
);

  localparam logic signed [11:0] TEMP_LO = 12'(T_MIN);
  localparam logic signed [11:0] TEMP_HI = 12'(T_MIN + T_STEP * (N_TBL - 1));
  localparam logic [6:0]         IDX_LAST_PAIR = 7'(N_TBL - 2);

  state_t state;

  logic [11:0]      adc_q;
  logic [31:0]      res_q;
  logic [31:0]      volt_q;
  logic [31:0]      k_q;
  logic [31:0]      q_q;
  logic [DIV_W-1:0] rt_q;
  logic [6:0]       idx;

  logic             div_start;
  logic [DIV_W-1:0] div_a;
  logic [DIV_W-1:0] div_b;
  logic             div_busy;
  logic             div_done;
  logic [DIV_W-1:0] div_quo;

  logic [31:0]        vfs_w;
  logic [DIV_W-1:0]   num_w;
  logic [DIV_W-1:0]   tbl_hi;
  logic [DIV_W-1:0]   tbl_lo;
  logic signed [11:0] interp_temp;

  seq_divider #(.W(DIV_W)) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .dividend (div_a),
    .divisor  (div_b),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_quo)
  );

  // Full-scale code and the resistance numerator share the MUL step. The
  // numerator is formed at DIV_W bits so 12b * 10 * 32b cannot overflow.
  // The interpolation quotient is 0..5, so its low three bits suffice.
  always_comb begin
    vfs_w       = q_q * volt_q;
    num_w       = DIV_W'(adc_q) * DIV_W'(10) * DIV_W'(res_q);
    tbl_hi      = DIV_W'(tbl_at(idx));
    tbl_lo      = DIV_W'(tbl_at(idx + 7'd1));
    interp_temp = 12'(int'(idx) * T_STEP + T_MIN + int'(div_quo[2:0]));
  end

  // Sequencer. Every exit towards DONE writes temp/clamp/err and raises done
  // together, so the DONE state is exactly the cycle in which done is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      temp      <= '0;
      clamp     <= 1'b0;
      err       <= 1'b0;
      adc_q     <= '0;
      res_q     <= '0;
      volt_q    <= '0;
      k_q       <= '0;
      q_q       <= '0;
      rt_q      <= '0;
      idx       <= '0;
      div_start <= 1'b0;
      div_a     <= '0;
      div_b     <= '0;
    end else begin
      done      <= 1'b0;
      div_start <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            adc_q     <= adc_code;
            res_q     <= res;
            volt_q    <= voltage;
            k_q       <= k;
            busy      <= 1'b1;
            div_a     <= DIV_W'(1000);
            div_b     <= DIV_W'(k);
            div_start <= (k != 32'd0);
            state     <= DIV_K;
          end
        end

        DIV_K: begin
          if (k_q == 32'd0) begin
            temp  <= TEMP_LO;
            clamp <= 1'b0;
            err   <= 1'b1;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end else if (div_done && !div_busy) begin
            q_q   <= 32'(div_quo);
            state <= MUL;
          end
        end

        // adc >= vfs also covers a zero denominator.
        MUL: begin
          if ({20'd0, adc_q} >= vfs_w) begin
            temp  <= TEMP_LO;
            clamp <= 1'b0;
            err   <= 1'b1;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end else begin
            div_a     <= num_w;
            div_b     <= DIV_W'(vfs_w - {20'd0, adc_q});
            div_start <= 1'b1;
            state     <= DIV_R;
          end
        end

        DIV_R: begin
          if (div_done) begin
            rt_q  <= div_quo;
            idx   <= '0;
            state <= SEARCH;
          end
        end

        // Entries decrease with index, so once rt fails rt >= tbl[i+1] it is
        // already known to be below tbl[i]; only the lower bound is tested
        // after the first entry.
        SEARCH: begin
          if (idx == 7'd0 && rt_q > tbl_hi) begin
            temp  <= TEMP_LO;
            clamp <= 1'b1;
            err   <= 1'b0;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end else if (rt_q >= tbl_lo) begin
            div_a     <= DIV_W'(5) * (tbl_hi - rt_q);
            div_b     <= tbl_hi - tbl_lo;
            div_start <= 1'b1;
            state     <= INTERP;
          end else if (idx == IDX_LAST_PAIR) begin
            temp  <= TEMP_HI;
            clamp <= 1'b1;
            err   <= 1'b0;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end else begin
            idx <= idx + 7'd1;
          end
        end

        INTERP: begin
          if (div_done) begin
            temp  <= interp_temp;
            clamp <= 1'b0;
            err   <= 1'b0;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_temp_from_adc.sv
// Directed bench for temp_from_adc: reset values, interpolated and clamped
// conversions, error inputs, output hold, mid-conversion reset, ignored
// starts, and a latency sweep over random ADC codes.
module tb_temp_from_adc;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic [11:0]        adc_code;
  logic [31:0]        res;
  logic [31:0]        voltage;
  logic [31:0]        k;
  logic               busy;
  logic               done;
  logic signed [11:0] temp;
  logic               clamp;
  logic               err;

  int check_count = 0;
  int pass_count  = 0;
  int done_count  = 0;

  temp_from_adc #(.DIV_W(48)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .adc_code (adc_code),
    .res      (res),
    .voltage  (voltage),
    .k        (k),
    .busy     (busy),
    .done     (done),
    .temp     (temp),
    .clamp    (clamp),
    .err      (err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done === 1'b1) done_count++;
  end

  task automatic checkOutput(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    check_count++;
    assert (obs === exp) pass_count++;
    else $error("[TB] FAIL %s: observed %0d (0x%h) expected %0d (0x%h)", tag, obs, obs, exp, exp);
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic applyStimulus(input logic [11:0] a, input logic [31:0] r,
                               input logic [31:0] v, input logic [31:0] kk);
    adc_code = a;
    res      = r;
    voltage  = v;
    k        = kk;
    start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Returns at the negedge of the done cycle (or after the cycle budget).
  task automatic runConv(input logic [11:0] a, input logic [31:0] r,
                         input logic [31:0] v, input logic [31:0] kk,
                         output int lat, output bit seen);
    @(negedge clk);
    applyStimulus(a, r, v, kk);
    adc_code = ~a;
    res      = 32'd7;
    voltage  = 32'd9;
    k        = 32'd5;
    lat  = 1;
    seen = 1'b0;
    while (!seen && lat < 400) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic checkConv(input string tag, input bit seen, input int lat,
                           input logic signed [11:0] et, input logic ec, input logic ee);
    checkOutput({tag, "_done"}, 48'(seen), 48'(1'b1));
    checkOutput({tag, "_temp"}, 48'(temp), 48'(et));
    checkOutput({tag, "_clamp"}, 48'(clamp), 48'(ec));
    checkOutput({tag, "_err"}, 48'(err), 48'(ee));
    checkOutput({tag, "_busy"}, 48'(busy), 48'(1'b0));
    checkOutput({tag, "_lat240"}, 48'(lat <= 240), 48'(1'b1));
  endtask

  initial begin
    int  lat;
    int  lat_norm;
    bit  seen;
    int  d0;
    logic [11:0] a;

    rst      = 1'b1;
    start    = 1'b0;
    adc_code = '0;
    res      = '0;
    voltage  = '0;
    k        = '0;
    repeat (3) @(negedge clk);
    checkOutput("rst_temp", 48'(temp), 48'(12'sd0));
    checkOutput("rst_clamp", 48'(clamp), 48'(1'b0));
    checkOutput("rst_err", 48'(err), 48'(1'b0));
    checkOutput("rst_busy", 48'(busy), 48'(1'b0));
    checkOutput("rst_done", 48'(done), 48'(1'b0));
    rst = 1'b0;

    // vfs = 4000; rt = adc*1e6/(4000-adc)
    runConv(12'd2000, 32'd100000, 32'd4, 32'd1, lat, seen);
    checkConv("adc2000", seen, lat, 12'sd25, 1'b0, 1'b0);
    lat_norm = lat;

    runConv(12'd1, 32'd100000, 32'd4, 32'd1, lat, seen);
    checkConv("adc1", seen, lat, 12'sd300, 1'b1, 1'b0);

    runConv(12'd3999, 32'd100000, 32'd4, 32'd1, lat, seen);
    checkConv("adc3999", seen, lat, -12'sd55, 1'b1, 1'b0);

    // rt = 333333 between tbl[21]=358800 and tbl[22]=297800 -> 50 + 2
    runConv(12'd1000, 32'd100000, 32'd4, 32'd1, lat, seen);
    checkConv("adc1000", seen, lat, 12'sd52, 1'b0, 1'b0);

    // rt = 3000000 between tbl[11]=3362000 and tbl[12]=2592000 -> 0 + 2
    runConv(12'd3000, 32'd100000, 32'd4, 32'd1, lat, seen);
    checkConv("adc3000", seen, lat, 12'sd2, 1'b0, 1'b0);

    // q = floor(1000/3) = 333, vfs = 3996, rt = 1998e6/1998 = 1000000
    runConv(12'd1998, 32'd100000, 32'd12, 32'd3, lat, seen);
    checkConv("k3", seen, lat, 12'sd25, 1'b0, 1'b0);

    // rt = floor(6934270/3999) = 1734 = tbl[71] exactly
    runConv(12'd1, 32'd693427, 32'd4, 32'd1, lat, seen);
    checkConv("tbl71", seen, lat, 12'sd300, 1'b0, 1'b0);

    repeat (5) @(negedge clk);
    checkOutput("hold_temp", 48'(temp), 48'(12'sd300));
    checkOutput("hold_done", 48'(done), 48'(1'b0));

    runConv(12'd2000, 32'd100000, 32'd4, 32'd0, lat, seen);
    checkConv("k0", seen, lat, -12'sd55, 1'b0, 1'b1);
    checkOutput("k0_shorter", 48'(lat < lat_norm), 48'(1'b1));

    runConv(12'd4000, 32'd100000, 32'd4, 32'd1, lat, seen);
    checkConv("adc_eq_vfs", seen, lat, -12'sd55, 1'b0, 1'b1);
    checkOutput("vfs_shorter", 48'(lat < lat_norm), 48'(1'b1));

    // Reset while scanning the table (scan of adc=1 runs roughly cycles 100..170)
    @(negedge clk);
    applyStimulus(12'd1, 32'd100000, 32'd4, 32'd1);
    repeat (115) @(negedge clk);
    checkOutput("pre_rst_busy", 48'(busy), 48'(1'b1));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abort_temp", 48'(temp), 48'(12'sd0));
    checkOutput("abort_clamp", 48'(clamp), 48'(1'b0));
    checkOutput("abort_err", 48'(err), 48'(1'b0));
    checkOutput("abort_busy", 48'(busy), 48'(1'b0));
    checkOutput("abort_done", 48'(done), 48'(1'b0));
    d0 = done_count;
    repeat (300) @(negedge clk);
    checkOutput("abort_no_done", 48'(done_count - d0), 48'(0));
    runConv(12'd2000, 32'd100000, 32'd4, 32'd1, lat, seen);
    checkConv("after_abort", seen, lat, 12'sd25, 1'b0, 1'b0);

    // Extra start pulses while busy must not retrigger or alter the result
    @(negedge clk);
    applyStimulus(12'd2000, 32'd100000, 32'd4, 32'd1);
    d0 = done_count;
    for (int c = 0; c < 300; c++) begin
      if (c == 10 || c == 60 || c == 150) begin
        adc_code = 12'd1;
        start    = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    checkOutput("busy_starts_done_cnt", 48'(done_count - d0), 48'(1));
    checkOutput("busy_starts_temp", 48'(temp), 48'(12'sd25));
    checkOutput("busy_starts_clamp", 48'(clamp), 48'(1'b0));

    // Start held during the done cycle is ignored
    runConv(12'd3000, 32'd100000, 32'd4, 32'd1, lat, seen);
    checkConv("pre_done_start", seen, lat, 12'sd2, 1'b0, 1'b0);
    adc_code = 12'd2000;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("done_start_busy", 48'(busy), 48'(1'b0));
    d0 = done_count;
    repeat (240) @(negedge clk);
    checkOutput("done_start_no_done", 48'(done_count - d0), 48'(0));
    checkOutput("done_start_temp", 48'(temp), 48'(12'sd2));

    // Latency sweep; codes at or above vfs=4000 are errors
    for (int n = 0; n < 8; n++) begin
      a = 12'($urandom_range(0, 4095));
      runConv(a, 32'd100000, 32'd4, 32'd1, lat, seen);
      checkOutput("sweep_done", 48'(seen), 48'(1'b1));
      checkOutput("sweep_lat240", 48'(lat <= 240), 48'(1'b1));
      checkOutput("sweep_err", 48'(err), 48'(a >= 12'd4000));
    end

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
